dvp_capture_multi: RTL and testbench
====================================

# dvp_capture_multi

- Parametrised DVP camera capture front end; successor to the fixed RGB565 capture block.
- Runs in the camera PCLK domain, upstream of the frame-buffer write path.
- Assembles 1, 2 or 3 bus beats into one pixel; pixel format is selectable per frame.
- Adds frame-skip, optional crop window, start-of-frame/end-of-line markers, frame counter and line-length error detection.

## Interface
- DW, 8: DVP data bus width (8 or 10).
- XW, 12: pixel column address width.
- YW, 11: line address width.
- SKIP_FRAMES, 10: frames discarded after reset (0 = none, max 15).
- VS_POL, 1: Vsync active level (1 = active-high).
- PCLK  in  1  camera pixel clock, sole clock.
- Rst_n  in  1  synchronous, active-low reset.
- Vsync  in  1  frame sync, polarity per VS_POL.
- Href  in  1  line valid, active-high.
- Data  in  DW  DVP data.
- fmt_sel  in  2  beats/pixel − 1: 0 = RAW8/Y, 1 = RGB565/YUV422, 2 = RGB888; 3 is reserved and treated as 1.
- crop_x0, crop_w  in  XW  crop column origin and width, in pixels.
- crop_y0, crop_h  in  YW  crop line origin and height.
- pix_valid  out  1  pixel strobe.
- pix_data  out  3*DW  first beat in the MS beat slot; unused beat slots are zero.
- pix_x  out  XW  column of pix_data, relative to the crop origin.
- pix_y  out  YW  line of pix_data, relative to the crop origin.
- pix_sof  out  1  with the first pixel_valid of a frame.
- pix_eol  out  1  with the last valid pixel of a line.
- frame_cnt  out  16  count of frames delivered, wrapping.
- line_err  out  1  one-cycle pulse on a bad line length.
- ready  out  1  high once skipping is complete.

## Operation
- **Input registers.** Vsync, Href and Data are registered once, unreset. The active-level Vsync is normalised to vs_r and the registered Href is href_r.
- **Frame start.** A vs_r rising edge marks frame start:
  - fmt_sel and all crop inputs are latched into shadow registers; mid-frame changes have no effect.
  - The line counter is cleared.
  - The skip counter increments, saturating at SKIP_FRAMES.
- **Frame enable.** ready is asserted only at a frame start at which the skip counter has already reached SKIP_FRAMES. Output never starts mid-frame.
- **Beat counting.** While href_r is high, a beat counter counts 0..fmt and wraps. On the beat where counter == fmt, the assembled pixel is emitted and the column counter increments.
- **Line end.** An href_r falling edge increments the line counter and clears the beat and column counters.
- **Length error.** If the beat counter is not 0 at an href_r fall, line_err pulses and the partial pixel is dropped.
- **Gating.** A pixel is emitted (pix_valid) only when all of the following hold:
  - ready = 1.
  - col ∈ [crop_x0, crop_x0+crop_w) and line ∈ [crop_y0, crop_y0+crop_h). Comparisons are made at XW+1 / YW+1 bits, so no wrap.
- **Empty window.** crop_w = 0 or crop_h = 0 produces no pixels, and frame_cnt does not increment.
- **Markers.**
  - pix_sof: first emitted pixel of the frame.
  - pix_eol: pixel at col = crop_x0+crop_w−1, or the last pixel before the href_r fall if that comes first.
- **frame_cnt.** Increments at the vs_r rising edge following a frame in which at least one pixel was emitted.
- **Counter saturation.** Column and line counters saturate at all-ones; there is no wrap.
- **Reset values.** Reset drives every output to 0 and clears all counters and shadows; this includes ready = 0.
- **Simultaneous events.**
  - A vs_r edge concurrent with href_r high is treated as frame start; the current line is abandoned without line_err.
  - Reset mid-frame restarts the skip count from 0.

## Timing
- **Latency.** pix_valid, pix_data, pix_x, pix_y, pix_sof and pix_eol rise 2 PCLK after the final beat of a pixel is on Data: 1 input register plus 1 output register.
- **Alignment.** All outputs are registered and mutually aligned.
- **line_err** is asserted 2 PCLK after Href falls on the bus.
- **ready** rises 2 PCLK after the qualifying Vsync edge on the bus.
- **Throughput.** One pixel per fmt+1 PCLK; there is no backpressure, and the consumer must accept every strobe.

## Configuration
- **DVP_CAPTURE_CROP_EN defined:** crop behaviour as above.
- **DVP_CAPTURE_CROP_EN undefined:**
  - Crop ports are ignored and the comparators are not built.
  - The window is the full frame; pix_x and pix_y are raw counters.
  - pix_eol is asserted only on the last pixel before the href_r fall.

## Structure
- **Package dvp_pkg:**
  - fmt enum: FMT_1B, FMT_2B, FMT_3B.
  - Constant MAX_BEATS = 3.
  - Function beats(fmt) returning 1..3.
- **Sub-module dvp_pixel_pack:**
  - Handles beat counting, shift-in of up to 3 beats, zero-fill of unused slots, and the partial-pixel/line_err decision.
  - The top level owns sync, skip, crop, markers and counters.

## Test plan
- **Skip:** SKIP_FRAMES = 2, 4 frames of 4×3 RGB565 (fmt_sel = 1) → no pix_valid in frames 1–2; frames 3–4 give 12 pixels each; frame_cnt ends at 2.
- **Formats:** fmt_sel = 0, line bytes 11,22,33 → pixels 0x00000B, 0x000016, 0x000021. fmt_sel = 2, beats A1,B2,C3 → pix_data 0xA1B2C3, pix_valid 2 cycles after C3.
- **Crop:** 8×6 frame, crop (2,1,3,2) → 6 pixels, x 0..2, y 0..1; pix_sof on the first; pix_eol at x = 2 of each line.
- **Bad line:** fmt_sel = 1, line of 7 beats → 3 pixels, then line_err pulse, with no 4th pixel.
- **Mid-frame:** fmt_sel changed mid-frame → takes effect only at the next frame. Rst_n pulsed low mid-line → all outputs are 0 the next cycle; skip restarts.
- **Polarity:** VS_POL = 0 with active-low Vsync → identical pixel stream to the VS_POL = 1 run.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP capture front end.
package dvp_pkg;
    typedef enum logic [1:0] {
        FMT_1B = 2'd0,
        FMT_2B = 2'd1,
        FMT_3B = 2'd2
    } fmt_e;

    localparam int MAX_BEATS = 3;

    function automatic logic [1:0] beats(fmt_e f);
        case (f)
            FMT_1B:  return 2'd1;
            FMT_3B:  return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    // The reserved selector value 3 behaves as two beats per pixel.
    function automatic fmt_e to_fmt(logic [1:0] sel);
        case (sel)
            2'd0:    return FMT_1B;
            2'd2:    return FMT_3B;
            default: return FMT_2B;
        endcase
    endfunction
endpackage

// File: rtl/dvp_capture_multi_if.sv
// DVP bus, per-frame configuration and pixel stream of the capture block.
interface dvp_capture_multi_if #(
    parameter int DW = 8,
    parameter int XW = 12,
    parameter int YW = 11
);
    logic            Vsync;
    logic            Href;
    logic [DW-1:0]   Data;
    logic [1:0]      fmt_sel;
    logic [XW-1:0]   crop_x0, crop_w;
    logic [YW-1:0]   crop_y0, crop_h;
    logic            pix_valid;
    logic [3*DW-1:0] pix_data;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic            pix_sof;
    logic            pix_eol;
    logic [15:0]     frame_cnt;
    logic            line_err;
    logic            ready;

    modport master (
        output Vsync, Href, Data, fmt_sel, crop_x0, crop_w, crop_y0, crop_h,
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
               frame_cnt, line_err, ready
    );
    modport slave (
        input  Vsync, Href, Data, fmt_sel, crop_x0, crop_w, crop_y0, crop_h,
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
               frame_cnt, line_err, ready
    );
endinterface

// File: rtl/dvp_pixel_pack.sv
// Beat counter and pixel assembler; emit/pixel are combinational off the
// registered bus so the top adds exactly one output register.
module dvp_pixel_pack import dvp_pkg::*; #(
    parameter int DW = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      href,
    input  logic [DW-1:0]             data,
    input  fmt_e                      fmt,
    input  logic                      abandon,
    output logic                      emit,
    output logic                      line_end,
    output logic                      line_err,
    output logic [MAX_BEATS*DW-1:0]   pixel
);
    logic          href_d, skip_line, fall;
    logic [1:0]    beat_cnt, last;
    logic [DW-1:0] b0, b1;

    assign last     = beats(fmt) - 2'd1;
    assign fall     = href_d & ~href;
    assign emit     = href & ~skip_line & ~abandon & (beat_cnt == last);
    assign line_end = fall & ~skip_line;
    assign line_err = line_end & (beat_cnt != 2'd0);

    always_comb begin
        pixel = '0;
        case (fmt)
            FMT_1B:  pixel = {{(2*DW){1'b0}}, data};
            FMT_2B:  pixel = {{DW{1'b0}}, b0, data};
            default: pixel = {b0, b1, data};
        endcase
    end

    // A frame start during an active line discards the rest of that line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            href_d    <= 1'b0;
            skip_line <= 1'b0;
            beat_cnt  <= 2'd0;
            b0        <= '0;
            b1        <= '0;
        end else begin
            href_d <= href;
            if (abandon) begin
                beat_cnt  <= 2'd0;
                skip_line <= href;
            end else if (fall) begin
                beat_cnt  <= 2'd0;
                skip_line <= 1'b0;
            end else if (href && !skip_line) begin
                beat_cnt <= (beat_cnt == last) ? 2'd0 : beat_cnt + 2'd1;
                if (beat_cnt == 2'd0) b0 <= data;
                if (beat_cnt == 2'd1) b1 <= data;
            end
        end
    end
endmodule

// File: rtl/dvp_capture_multi.sv
// DVP capture top: sync, frame skip, crop window, markers, counters.
// Crop window is built only when DVP_CAPTURE_CROP_EN is defined.
module dvp_capture_multi import dvp_pkg::*; #(
    parameter int DW          = 8,
    parameter int XW          = 12,
    parameter int YW          = 11,
    parameter int SKIP_FRAMES = 10,
    parameter bit VS_POL      = 1'b1
) (
    input logic                PCLK,
    input logic                Rst_n,
    dvp_capture_multi_if.slave bus
);
    localparam logic [3:0] SKIP_W = 4'(SKIP_FRAMES);

    logic                      vs_r, vs_d, href_r, fs;
    logic [DW-1:0]             data_r;
    fmt_e                      fmt_sh;
    logic [3:0]                skip_cnt;
    logic                      rdy, sof_pend, got_pix;
    logic [XW-1:0]             col, x_rel;
    logic [YW-1:0]             row, y_rel;
    logic                      in_win, at_xend, vld, eol_n;
    logic                      emit, line_end, perr;
    logic [MAX_BEATS*DW-1:0]   pixel;

    always_ff @(posedge PCLK) begin
        vs_r   <= (bus.Vsync == VS_POL);
        href_r <= bus.Href;
        data_r <= bus.Data;
    end

    assign fs = vs_r & ~vs_d;

    dvp_pixel_pack #(.DW(DW)) u_pack (
        .clk      (PCLK),
        .rst_n    (Rst_n),
        .href     (href_r),
        .data     (data_r),
        .fmt      (fmt_sh),
        .abandon  (fs),
        .emit     (emit),
        .line_end (line_end),
        .line_err (perr),
        .pixel    (pixel)
    );

`ifdef DVP_CAPTURE_CROP_EN
    logic [XW-1:0] cx0, cw;
    logic [YW-1:0] cy0, ch;
    logic [XW:0]   x_hi;
    logic [YW:0]   y_hi;

    always_ff @(posedge PCLK) begin
        if (!Rst_n) begin
            cx0 <= '0; cw <= '0; cy0 <= '0; ch <= '0;
        end else if (fs) begin
            cx0 <= bus.crop_x0; cw <= bus.crop_w;
            cy0 <= bus.crop_y0; ch <= bus.crop_h;
        end
    end

    // One extra bit so origin + size never wraps.
    assign x_hi    = {1'b0, cx0} + {1'b0, cw};
    assign y_hi    = {1'b0, cy0} + {1'b0, ch};
    assign in_win  = ({1'b0, col} >= {1'b0, cx0}) && ({1'b0, col} < x_hi) &&
                     ({1'b0, row} >= {1'b0, cy0}) && ({1'b0, row} < y_hi);
    assign at_xend = ({1'b0, col} + (XW+1)'(1)) == x_hi;
    assign x_rel   = col - cx0;
    assign y_rel   = row - cy0;
`else
    assign in_win  = 1'b1;
    assign at_xend = 1'b0;
    assign x_rel   = col;
    assign y_rel   = row;
`endif

    // Raw Href is next cycle's href_r: low here means this pixel ends the line.
    assign vld   = emit & rdy & in_win;
    assign eol_n = vld & (at_xend | ~bus.Href);
    assign bus.ready = rdy;

    always_ff @(posedge PCLK) begin
        if (!Rst_n) begin
            vs_d          <= 1'b0;
            fmt_sh        <= FMT_1B;
            skip_cnt      <= '0;
            rdy           <= 1'b0;
            sof_pend      <= 1'b0;
            got_pix       <= 1'b0;
            col           <= '0;
            row           <= '0;
            bus.frame_cnt <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
            bus.line_err  <= 1'b0;
        end else begin
            vs_d <= vs_r;
            if (fs) begin
                fmt_sh   <= to_fmt(bus.fmt_sel);
                row      <= '0;
                sof_pend <= 1'b1;
                got_pix  <= 1'b0;
                if (got_pix) bus.frame_cnt <= bus.frame_cnt + 16'd1;
                if (skip_cnt == SKIP_W) rdy <= 1'b1;
                else                    skip_cnt <= skip_cnt + 4'd1;
            end else begin
                if (line_end && row != '1) row <= row + 1'b1;
                if (vld) begin
                    sof_pend <= 1'b0;
                    got_pix  <= 1'b1;
                end
            end
            if (fs || line_end)       col <= '0;
            else if (emit && col != '1) col <= col + 1'b1;

            bus.pix_valid <= vld;
            bus.pix_sof   <= vld & sof_pend;
            bus.pix_eol   <= eol_n;
            bus.line_err  <= perr;
            if (vld) begin
                bus.pix_data <= pixel;
                bus.pix_x    <= x_rel;
                bus.pix_y    <= y_rel;
            end
        end
    end
endmodule

// File: tb/tb_dvp_capture_multi.sv
// Scoreboard bench: an active-high and an active-low Vsync instance share one stream.
module tb_dvp_capture_multi;
    localparam int DW = 8, XW = 12, YW = 11, SKIP = 2;

    logic PCLK = 1'b0;
    logic Rst_n = 1'b0;
    always #5 PCLK = ~PCLK;

    dvp_capture_multi_if #(.DW(DW), .XW(XW), .YW(YW)) bus_a ();
    dvp_capture_multi_if #(.DW(DW), .XW(XW), .YW(YW)) bus_b ();

    assign bus_b.Vsync   = ~bus_a.Vsync;
    assign bus_b.Href    = bus_a.Href;
    assign bus_b.Data    = bus_a.Data;
    assign bus_b.fmt_sel = bus_a.fmt_sel;
    assign bus_b.crop_x0 = bus_a.crop_x0;
    assign bus_b.crop_w  = bus_a.crop_w;
    assign bus_b.crop_y0 = bus_a.crop_y0;
    assign bus_b.crop_h  = bus_a.crop_h;

    dvp_capture_multi #(.DW(DW), .XW(XW), .YW(YW), .SKIP_FRAMES(SKIP), .VS_POL(1'b1))
        dut_a (.PCLK(PCLK), .Rst_n(Rst_n), .bus(bus_a.slave));
    dvp_capture_multi #(.DW(DW), .XW(XW), .YW(YW), .SKIP_FRAMES(SKIP), .VS_POL(1'b0))
        dut_b (.PCLK(PCLK), .Rst_n(Rst_n), .bus(bus_b.slave));

    typedef struct {
        logic [48:0] v;
        int          cyc;
    } exp_t;

    exp_t q_a[$], q_b[$];
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   m_skip = 0, m_fcnt = 0, m_fmt = 0, m_line = 0;
    int   m_cx0 = 0, m_cw = 0, m_cy0 = 0, m_ch = 0;
    bit   m_ready = 0, m_got = 0, m_sof = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit win(int x, int y);
`ifdef DVP_CAPTURE_CROP_EN
        return x >= m_cx0 && x < m_cx0 + m_cw && y >= m_cy0 && y < m_cy0 + m_ch;
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge PCLK) begin
        if (bus_a.pix_valid) begin
            chk("vld_a", 64'(bus_a.pix_valid), 64'(q_a.size() != 0));
            if (q_a.size() != 0) begin
                exp_t e;
                e = q_a.pop_front();
                chk("pix_a", 64'({bus_a.pix_data, bus_a.pix_x, bus_a.pix_y,
                                  bus_a.pix_sof, bus_a.pix_eol}), 64'(e.v));
                chk("lat_a", 64'(cyc), 64'(e.cyc));
            end
        end
        if (bus_b.pix_valid) begin
            chk("vld_b", 64'(bus_b.pix_valid), 64'(q_b.size() != 0));
            if (q_b.size() != 0) begin
                exp_t e;
                e = q_b.pop_front();
                chk("pix_b", 64'({bus_b.pix_data, bus_b.pix_x, bus_b.pix_y,
                                  bus_b.pix_sof, bus_b.pix_eol}), 64'(e.v));
                chk("lat_b", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic rst_chk(input string tag);
        chk({tag, "_pix_a"}, 64'({bus_a.pix_valid, bus_a.pix_data, bus_a.pix_x,
                                  bus_a.pix_y, bus_a.pix_sof, bus_a.pix_eol}), 64'd0);
        chk({tag, "_st_a"},  64'({bus_a.frame_cnt, bus_a.line_err, bus_a.ready}), 64'd0);
        chk({tag, "_pix_b"}, 64'({bus_b.pix_valid, bus_b.pix_data, bus_b.pix_x,
                                  bus_b.pix_y, bus_b.pix_sof, bus_b.pix_eol}), 64'd0);
        chk({tag, "_st_b"},  64'({bus_b.frame_cnt, bus_b.line_err, bus_b.ready}), 64'd0);
    endtask

    task automatic vsync();
        if (m_got) m_fcnt++;
        m_got = 0; m_sof = 1; m_line = 0;
        if (m_skip == SKIP) m_ready = 1;
        else                m_skip++;
        m_fmt = (bus_a.fmt_sel == 2'd0) ? 0 : (bus_a.fmt_sel == 2'd2) ? 2 : 1;
        m_cx0 = int'(bus_a.crop_x0); m_cw = int'(bus_a.crop_w);
        m_cy0 = int'(bus_a.crop_y0); m_ch = int'(bus_a.crop_h);
        @(negedge PCLK) bus_a.Vsync = 1'b1;
        repeat (2) @(negedge PCLK);
        bus_a.Vsync = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rdy_a",  64'(bus_a.ready), 64'(m_ready));
        chk("rdy_b",  64'(bus_b.ready), 64'(m_ready));
        chk("fcnt_a", 64'(bus_a.frame_cnt), 64'(m_fcnt));
        chk("fcnt_b", 64'(bus_b.frame_cnt), 64'(m_fcnt));
    endtask

    task automatic line(input int nbeat, input int seed, input int step);
        int          b, x, xoff, yoff;
        logic [23:0] acc;
        logic [7:0]  d;
        bit          eol;
        exp_t        e;
        b = m_fmt + 1;
        acc = '0;
`ifdef DVP_CAPTURE_CROP_EN
        xoff = m_cx0; yoff = m_cy0;
`else
        xoff = 0; yoff = 0;
`endif
        for (int i = 0; i < nbeat; i++) begin
            @(negedge PCLK);
            d = 8'(seed + i * step);
            bus_a.Href = 1'b1;
            bus_a.Data = d;
            acc = {acc[15:0], d};
            if (i % b == b - 1) begin
                x = i / b;
                if (m_ready && win(x, m_line)) begin
                    eol = (i == nbeat - 1);
`ifdef DVP_CAPTURE_CROP_EN
                    if (x == m_cx0 + m_cw - 1) eol = 1'b1;
`endif
                    e.v   = {acc, 12'(x - xoff), 11'(m_line - yoff), m_sof, eol};
                    e.cyc = cyc + 2;
                    q_a.push_back(e);
                    q_b.push_back(e);
                    m_sof = 0;
                    m_got = 1;
                end
                acc = '0;
            end
        end
        @(negedge PCLK);
        bus_a.Href = 1'b0;
        bus_a.Data = '0;
        repeat (2) @(negedge PCLK);
        chk("lerr_a", 64'(bus_a.line_err), 64'(nbeat % b != 0));
        chk("lerr_b", 64'(bus_b.line_err), 64'(nbeat % b != 0));
        repeat (3) @(negedge PCLK);
        m_line++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog n_tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.Vsync = 1'b0; bus_a.Href = 1'b0; bus_a.Data = '0;
        bus_a.fmt_sel = 2'd1;
        bus_a.crop_x0 = '0; bus_a.crop_w = '1;
        bus_a.crop_y0 = '0; bus_a.crop_h = '1;
        repeat (3) @(negedge PCLK);
        rst_chk("rst0");
        Rst_n = 1'b1;
        @(negedge PCLK);

        // Frame skip: two 4x3 RGB565 frames dropped, two delivered
        for (int f = 0; f < 4; f++) begin
            vsync();
            for (int l = 0; l < 3; l++) line(8, f * 64 + l * 16, 1);
        end

        // Formats, including a selector change that waits for the next frame
        bus_a.fmt_sel = 2'd0;
        vsync();
        line(3, 11, 11);
        bus_a.fmt_sel = 2'd2;
        line(3, 'hA1, 'h11);
        vsync();
        line(3, 'hA1, 'h11);
        line(6, 1, 3);

        // Short line with the reserved selector (two beats per pixel)
        bus_a.fmt_sel = 2'd3;
        vsync();
        line(8, 'h40, 1);
        line(7, 'h50, 1);

        // Crop window on an 8x6 frame
        bus_a.fmt_sel = 2'd0;
        bus_a.crop_x0 = 12'd2; bus_a.crop_w = 12'd3;
        bus_a.crop_y0 = 11'd1; bus_a.crop_h = 11'd2;
        vsync();
        for (int l = 0; l < 6; l++) line(8, l * 8, 1);

        // Empty window
        bus_a.crop_w = '0;
        vsync();
        line(4, 'h70, 1);
        line(4, 'h80, 1);
        bus_a.crop_x0 = '0; bus_a.crop_w = '1;
        bus_a.crop_y0 = '0; bus_a.crop_h = '1;
        bus_a.fmt_sel = 2'd1;
        vsync();

        // Reset pulsed in the middle of a line
        @(negedge PCLK);
        bus_a.Href = 1'b1; bus_a.Data = 8'h05;
        @(negedge PCLK);
        Rst_n = 1'b0; bus_a.Data = 8'h06;
        @(negedge PCLK);
        rst_chk("rst_mid");
        bus_a.Href = 1'b0; bus_a.Data = '0;
        @(negedge PCLK);
        Rst_n = 1'b1;
        m_skip = 0; m_ready = 0; m_fcnt = 0; m_got = 0; m_sof = 0; m_line = 0;
        repeat (2) @(negedge PCLK);
        for (int f = 0; f < 3; f++) begin
            vsync();
            line(4, 'h90 + f * 8, 1);
        end
        vsync();

        repeat (5) @(negedge PCLK);
        chk("left_a", 64'(q_a.size()), 64'd0);
        chk("left_b", 64'(q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
